// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture path.
// sample_t is sized for the default channel width used across the pedal chain.
package i2s_pkg;

   localparam int DATA_W_DEF = 24;

   typedef logic [DATA_W_DEF-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } rx_state_t;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_edge_detect.sv
// Finds sclk falling edges in the mclk domain and flags lrclk changes seen there.
// sclk and lrclk are mclk-synchronous, so no synchroniser stages are needed.
module i2s_edge_detect (
   input  logic mclk,
   input  logic rst,
   input  logic sclk,
   input  logic lrclk,
   output logic sample_pt,
   output logic lr_change
);

   logic sclk_q;
   logic prev_lr;

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         sclk_q  <= 1'b0;
         prev_lr <= 1'b0;
      end else begin
         sclk_q <= sclk;
         if (sample_pt)
            prev_lr <= lrclk;
      end
   end

   assign sample_pt = sclk_q & ~sclk;
   assign lr_change = sample_pt & (lrclk ^ prev_lr);

endmodule

// File: rtl/i2s_receiver.sv
// I2S serial-to-parallel capture: one left/right pair per frame with a valid strobe.
// state | meaning:  IDLE wait for first lrclk change | DELAY skip edges before MSB | SHIFT capture bits | PAD ignore rest of slot
module i2s_receiver
   import i2s_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int SLOT_W    = 32,
   parameter int BIT_DELAY = 1
) (
   input  logic              mclk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              lrclk,
   input  logic              sdin,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              sample_valid,
   output logic              frame_err
);

   // cnt holds the slot bit number (1 = the edge where lrclk changed); all
   // phase boundaries are compares of that single counter against constants.
   localparam logic [5:0] DELAY_END = 6'(BIT_DELAY);
   localparam logic [5:0] LAST_BIT  = 6'(BIT_DELAY + DATA_W);
   localparam logic [5:0] SLOT_END  = 6'(SLOT_W);
   localparam rx_state_t  START_ST  = (BIT_DELAY == 0) ? SHIFT : DELAY;

   logic              sample_pt;
   logic              lr_change;
   rx_state_t         state, state_nxt;
   logic [5:0]        cnt, cnt_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shadow;
   logic [DATA_W-1:0] word_nxt;
   logic              ch;
   logic              left_ok;
   logic              load_ch, shift_en, commit, short_err, long_err;

   i2s_edge_detect u_edge (
      .mclk      (mclk),
      .rst       (rst),
      .sclk      (sclk),
      .lrclk     (lrclk),
      .sample_pt (sample_pt),
      .lr_change (lr_change)
   );

   assign word_nxt = DATA_W'({shreg, sdin});

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load_ch   = 1'b0;
      shift_en  = 1'b0;
      commit    = 1'b0;
      short_err = 1'b0;
      long_err  = 1'b0;
      if (lr_change) begin
         state_nxt = START_ST;
         cnt_nxt   = 6'd1;
         load_ch   = 1'b1;
         short_err = (state == DELAY) || (state == SHIFT);
      end else if (sample_pt) begin
         case (state)
            DELAY: begin
               cnt_nxt = cnt + 6'd1;
               if (cnt == DELAY_END)
                  state_nxt = SHIFT;
            end
            SHIFT: begin
               shift_en = 1'b1;
               cnt_nxt  = cnt + 6'd1;
               if (cnt == LAST_BIT) begin
                  commit    = 1'b1;
                  state_nxt = PAD;
               end
            end
            PAD: begin
               if (cnt == SLOT_END) begin
                  long_err  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         shreg        <= '0;
         shadow       <= '0;
         ch           <= CH_LEFT;
         left_ok      <= 1'b0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= short_err | long_err;
         if (load_ch) begin
            ch    <= lrclk;
            shreg <= '0;
         end
         if (short_err && (ch == CH_LEFT))
            left_ok <= 1'b0;
         if (shift_en)
            shreg <= word_nxt;
         if (commit) begin
            if (ch == CH_LEFT) begin
               shadow  <= word_nxt;
               left_ok <= 1'b1;
            end else if (left_ok) begin
               left_data    <= shadow;
               right_data   <= word_nxt;
               sample_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: sclk = mclk/4, 32-bit slots, MSB two sample points after the lrclk change.
module tb_i2s_receiver;

   logic        mclk = 1'b0;
   logic        rst;
   logic        sclk;
   logic        lrclk;
   logic        sdin;
   logic [23:0] left_data;
   logic [23:0] right_data;
   logic        sample_valid;
   logic        frame_err;

   always #5 mclk = ~mclk;

   i2s_receiver #(.DATA_W(24), .SLOT_W(32), .BIT_DELAY(1)) dut (
      .mclk         (mclk),
      .rst          (rst),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .sdin         (sdin),
      .left_data    (left_data),
      .right_data   (right_data),
      .sample_valid (sample_valid),
      .frame_err    (frame_err)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_valid  = 0;
   int          n_err    = 0;
   int          n_both   = 0;
   int          valid_bit = 0;
   int          err_bit   = 0;
   int          bit_idx   = 0;
   logic [23:0] got_l = '0;
   logic [23:0] got_r = '0;

   always @(negedge mclk) begin
      if (sample_valid) begin
         n_valid++;
         got_l     = left_data;
         got_r     = right_data;
         valid_bit = bit_idx;
      end
      if (frame_err) begin
         n_err++;
         err_bit = bit_idx;
      end
      if (sample_valid && frame_err)
         n_both++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic send_bit(input logic lr, input logic d);
      lrclk = lr;
      sdin  = d;
      sclk  = 1'b1;
      repeat (2) @(negedge mclk);
      sclk  = 1'b0;
      repeat (2) @(negedge mclk);
   endtask

   // Slot bit 1 carries the lrclk change, bit 2 is skipped, bits 3..26 are MSB..LSB.
   task automatic send_slot(input logic lr, input logic [23:0] word, input int nbits);
      logic d;
      for (int i = 0; i < nbits; i++) begin
         bit_idx = i + 1;
         if (i >= 2 && i < 26)
            d = word[25-i];
         else
            d = 1'($urandom_range(0, 1));
         send_bit(lr, d);
      end
   endtask

   task automatic async_reset(input logic lr_hold);
      @(negedge mclk);
      #2 rst = 1'b1;
      lrclk = lr_hold;
      #1;
      check("rst_left_async", 32'(left_data), 32'h0);
      check("rst_right_async", 32'(right_data), 32'h0);
      check("rst_valid_async", 32'(sample_valid), 32'h0);
      @(negedge mclk);
      repeat (3) @(negedge mclk);
      rst = 1'b0;
      @(negedge mclk);
   endtask

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          slot_len;
      logic [23:0] exp_l;
      logic [23:0] exp_r;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int v0, e0;
      logic [23:0] rl, rr;

      vecs[0] = '{24'hA5A5A5, 24'h123456, 32, 24'hA5A5A5, 24'h123456};
      vecs[1] = '{24'h000001, 24'hFFFFFF, 32, 24'h000001, 24'hFFFFFF};
      vecs[2] = '{24'h7FFFFF, 24'h800000, 26, 24'h7FFFFF, 24'h800000};
      vecs[3] = '{24'h800001, 24'h7FFFFE, 28, 24'h800001, 24'h7FFFFE};
      vecs[4] = '{24'h000000, 24'hC0FFEE, 32, 24'h000000, 24'hC0FFEE};
      vecs[5] = '{24'hDEAD01, 24'h00BEEF, 27, 24'hDEAD01, 24'h00BEEF};

      rst   = 1'b1;
      sclk  = 1'b0;
      lrclk = 1'b0;
      sdin  = 1'b0;
      repeat (3) @(negedge mclk);
      check("reset_left", 32'(left_data), 32'h0);
      check("reset_right", 32'(right_data), 32'h0);
      check("reset_valid", 32'(sample_valid), 32'h0);
      check("reset_err", 32'(frame_err), 32'h0);
      rst = 1'b0;
      @(negedge mclk);

      // A right slot with no left before it must not be presented.
      v0 = n_valid; e0 = n_err;
      send_slot(1'b1, 24'h999999, 32);
      check("orphan_right_valid", 32'(n_valid - v0), 32'd0);

      for (int k = 0; k < 6; k++) begin
         v0 = n_valid; e0 = n_err;
         send_slot(1'b0, vecs[k].l, vecs[k].slot_len);
         send_slot(1'b1, vecs[k].r, vecs[k].slot_len);
         check($sformatf("vec%0d_valid_count", k), 32'(n_valid - v0), 32'd1);
         check($sformatf("vec%0d_err_count", k), 32'(n_err - e0), 32'd0);
         check($sformatf("vec%0d_left", k), 32'(got_l), 32'(vecs[k].exp_l));
         check($sformatf("vec%0d_right", k), 32'(got_r), 32'(vecs[k].exp_r));
         check($sformatf("vec%0d_valid_bit", k), 32'(valid_bit), 32'd26);
      end
      check("outputs_hold_left", 32'(left_data), 32'hDEAD01);
      check("outputs_hold_right", 32'(right_data), 32'h00BEEF);

      // Short left slot: error on the next change, the right word is dropped.
      v0 = n_valid; e0 = n_err;
      send_slot(1'b0, 24'h111111, 16);
      send_slot(1'b1, 24'h222222, 32);
      check("short_err_count", 32'(n_err - e0), 32'd1);
      check("short_err_bit", 32'(err_bit), 32'd1);
      check("short_no_valid", 32'(n_valid - v0), 32'd0);
      v0 = n_valid; e0 = n_err;
      send_slot(1'b0, 24'h7FFFFF, 32);
      send_slot(1'b1, 24'h800000, 32);
      check("short_recover_valid", 32'(n_valid - v0), 32'd1);
      check("short_recover_err", 32'(n_err - e0), 32'd0);
      check("short_recover_left", 32'(got_l), 32'h7FFFFF);
      check("short_recover_right", 32'(got_r), 32'h800000);

      // Long slot: single error on bit 33, nothing further while lrclk is held.
      e0 = n_err;
      send_slot(1'b0, 24'h0F0F0F, 40);
      check("long_err_count", 32'(n_err - e0), 32'd1);
      check("long_err_bit", 32'(err_bit), 32'd33);
      send_slot(1'b1, 24'h333333, 32);
      v0 = n_valid; e0 = n_err;
      send_slot(1'b0, 24'h654321, 32);
      send_slot(1'b1, 24'h0ABCDE, 32);
      check("long_recover_valid", 32'(n_valid - v0), 32'd1);
      check("long_recover_err", 32'(n_err - e0), 32'd0);
      check("long_recover_left", 32'(got_l), 32'h654321);
      check("long_recover_right", 32'(got_r), 32'h0ABCDE);

      // Reset after 10 bits of a left slot.
      send_slot(1'b0, 24'h444444, 10);
      v0 = n_valid; e0 = n_err;
      async_reset(1'b0);
      check("midrst_no_pulse", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
      send_slot(1'b1, 24'h555555, 32);
      send_slot(1'b0, 24'h5A5A5A, 32);
      send_slot(1'b1, 24'hC3C3C3, 32);
      check("midrst_valid", 32'(n_valid - v0), 32'd1);
      check("midrst_err", 32'(n_err - e0), 32'd0);
      check("midrst_left", 32'(got_l), 32'h5A5A5A);
      check("midrst_right", 32'(got_r), 32'hC3C3C3);

      // First frame after reset starts in the middle of a right slot.
      async_reset(1'b1);
      v0 = n_valid;
      send_slot(1'b1, 24'h666666, 10);
      check("first_partial_no_valid", 32'(n_valid - v0), 32'd0);
      send_slot(1'b0, 24'h000001, 32);
      send_slot(1'b1, 24'hFFFFFF, 32);
      check("first_pair_valid", 32'(n_valid - v0), 32'd1);
      check("first_pair_left", 32'(got_l), 32'h000001);
      check("first_pair_right", 32'(got_r), 32'hFFFFFF);

      // Loopback-style stream: 50 random pairs = 100 samples.
      for (int k = 0; k < 50; k++) begin
         rl = 24'($urandom);
         rr = 24'($urandom);
         v0 = n_valid;
         send_slot(1'b0, rl, 32);
         send_slot(1'b1, rr, 32);
         check($sformatf("loop%0d_valid", k), 32'(n_valid - v0), 32'd1);
         check($sformatf("loop%0d_left", k), 32'(got_l), 32'(rl));
         check($sformatf("loop%0d_right", k), 32'(got_r), 32'(rr));
      end

      check("never_valid_and_err", 32'(n_both), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
